// File: rtl/mcu51_mem_pkg.sv
// Shared definitions for the CPU-side code/data memory.
//   ADDR_W_DEF / DATA_W_DEF : default bus widths
//   CNT_W_DEF               : width of the loader byte counter (one extra bit
//                             so a full-depth load can be counted)
//   mem_state_t             : LOAD / RUN state encoding
package mcu51_mem_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_DEF  = ADDR_W_DEF + 1;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } mem_state_t;

endpackage

// File: rtl/code_mem_array.sv
// Storage for code_mem_responder: DEPTH x DATA_W words, one synchronous write
// port (caller muxes loader/CPU onto it) and one read port.
// Optional macro CODE_MEM_WAIT_EN: replaces the asynchronous read output with
// a registered read (rd_q captured from mem[raddr] when rd_cap is high).
// Ports:
//   clk    : system clock
//   we     : write enable, mem[waddr] <= wdata on rising edge
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : asynchronous read data (macro undefined)
//   rd_cap : capture strobe for registered read (macro defined)
//   rd_q   : registered read data (macro defined)
module code_mem_array #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
`ifdef CODE_MEM_WAIT_EN
   input  logic              rd_cap,
   output logic [DATA_W-1:0] rd_q
`else
   output logic [DATA_W-1:0] rdata
`endif
);

   // Contents survive reset on purpose: a reset mid-load keeps older bytes.
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

`ifdef CODE_MEM_WAIT_EN
   always_ff @(posedge clk) begin
      if (rd_cap) rd_q <= mem[raddr];
   end
`else
   assign rdata = mem[raddr];
`endif

endmodule

// File: rtl/code_mem_responder.sv
// CPU-side program/data memory. Boots in LOAD, filling itself from a byte
// stream while holding the CPU off, then serves CPU reads/writes in RUN.
// Optional macro CODE_MEM_WAIT_EN: reads take one wait state (mem_ready low
// on the first read cycle of an address, data from a register afterwards).
// Ports:
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   addr_bus   : CPU address
//   data_bus   : shared data bus, driven only on a RUN read, else high-Z
//   read_en    : CPU read request
//   write_en   : CPU write request (data_bus sampled at the edge)
//   load_valid : loader byte valid
//   load_data  : loader byte
//   load_last  : final loader byte marker
//   load_ready : high in LOAD
//   cpu_hold   : high in LOAD
//   load_count : bytes accepted since reset
//   mem_ready  : read data valid on data_bus
//   bus_err    : sticky protocol error
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_LOAD | accepting loader bytes, CPU held off, bus never driven
// ST_RUN  | serving CPU reads/writes, loader ignored
module code_mem_responder
   import mcu51_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr_bus,
   inout  wire  [DATA_W-1:0] data_bus,
   input  logic              read_en,
   input  logic              write_en,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              cpu_hold,
   output logic [ADDR_W:0]   load_count,
   output logic              mem_ready,
   output logic              bus_err
);

   mem_state_t        state_q, state_d;
   logic [ADDR_W-1:0] load_ptr_q;
   logic [ADDR_W:0]   load_count_q;
   logic              bus_err_q;
   logic              in_run;
   logic              accept;
   logic              ptr_at_end;
   logic              cpu_we;
   logic              mem_we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] bus_val;
   logic              bus_drive;

   assign in_run     = (state_q == ST_RUN);
   assign accept     = !in_run && load_valid;
   assign ptr_at_end = (load_ptr_q == ADDR_W'(DEPTH-1));

   // A simultaneous read wins; the write is dropped and flagged.
   assign cpu_we = in_run && write_en && !read_en;
   assign mem_we = accept || cpu_we;
   assign waddr  = accept ? load_ptr_q : addr_bus;
   assign wdata  = accept ? load_data  : data_bus;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_LOAD;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD: if (accept && (load_last || ptr_at_end)) state_d = ST_RUN;
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_LOAD;
      endcase
   end

`ifdef CODE_MEM_WAIT_EN
   logic              rd_valid_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic              rd_hit;
   logic              rd_cap;
   logic [DATA_W-1:0] rd_q;

   // A hit means the previous cycle already captured this address.
   assign rd_hit = rd_valid_q && (rd_addr_q == addr_bus);
   assign rd_cap = in_run && read_en && !rd_hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_valid_q <= 1'b0;
         rd_addr_q  <= '0;
      end else begin
         rd_valid_q <= in_run && read_en;
         rd_addr_q  <= addr_bus;
      end
   end

   assign bus_val = rd_q;
`endif

   always_comb begin
      load_ready = !in_run;
      cpu_hold   = !in_run;
`ifdef CODE_MEM_WAIT_EN
      mem_ready  = in_run && read_en && rd_hit;
      bus_drive  = mem_ready;
`else
      mem_ready  = 1'b1;
      bus_drive  = in_run && read_en;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_ptr_q   <= '0;
         load_count_q <= '0;
         bus_err_q    <= 1'b0;
      end else begin
         if (accept) begin
            load_count_q <= load_count_q + 1'b1;
            // The byte at the top address ends the load; keep the pointer there.
            if (!ptr_at_end) load_ptr_q <= load_ptr_q + 1'b1;
         end
         if ((!in_run && (read_en || write_en)) || (in_run && read_en && write_en))
            bus_err_q <= 1'b1;
      end
   end

   code_mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk    (clk),
      .we     (mem_we),
      .waddr  (waddr),
      .wdata  (wdata),
      .raddr  (addr_bus),
`ifdef CODE_MEM_WAIT_EN
      .rd_cap (rd_cap),
      .rd_q   (rd_q)
`else
      .rdata  (bus_val)
`endif
   );

   assign data_bus   = bus_drive ? bus_val : {DATA_W{1'bz}};
   assign load_count = load_count_q;
   assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_code_mem_responder.sv
// Directed bench for code_mem_responder. The bus net is pulled up, so an
// undriven data_bus reads as 8'hFF.
module tb_code_mem_responder;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] addr_bus;
   logic       read_en;
   logic       write_en;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_last;
   logic       load_ready;
   logic       cpu_hold;
   logic [8:0] load_count;
   logic       mem_ready;
   logic       bus_err;
   logic [7:0] tb_drv;
   logic       tb_drv_en;
   tri1  [7:0] data_bus;

   int n_checks = 0;
   int n_fail   = 0;

   assign data_bus = tb_drv_en ? tb_drv : 8'hzz;

   always #5 clk = ~clk;

   code_mem_responder dut (
      .clk        (clk),
      .reset      (reset),
      .addr_bus   (addr_bus),
      .data_bus   (data_bus),
      .read_en    (read_en),
      .write_en   (write_en),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .cpu_hold   (cpu_hold),
      .load_count (load_count),
      .mem_ready  (mem_ready),
      .bus_err    (bus_err)
   );

`ifdef CODE_MEM_WAIT_EN
   localparam logic RESET_READY = 1'b0;
`else
   localparam logic RESET_READY = 1'b1;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues a read and returns what the bus shows once data should be valid.
   task automatic do_read(input logic [7:0] a, output logic [7:0] d, output logic r);
      addr_bus = a;
      read_en  = 1'b1;
`ifdef CODE_MEM_WAIT_EN
      tick();
`endif
      #1;
      d = data_bus;
      r = mem_ready;
   endtask

   task automatic load_byte(input logic [7:0] b, input logic last);
      load_valid = 1'b1;
      load_data  = b;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #2;
      n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready got %b want 1", load_ready); end
      n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_hold got %b want 1", cpu_hold); end
      n_checks++; if (load_count !== 9'd0) begin n_fail++; $display("FAIL reset_load_count got %0d want 0", load_count); end
      n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
      n_checks++; if (mem_ready !== RESET_READY) begin n_fail++; $display("FAIL reset_mem_ready got %b want %b", mem_ready, RESET_READY); end
      n_checks++; if (data_bus !== 8'hFF) begin n_fail++; $display("FAIL reset_bus_z got %h want FF(pulled)", data_bus); end
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_load4();
      logic [7:0] bytes [4];
      bytes[0] = 8'h04; bytes[1] = 8'h74; bytes[2] = 8'h12; bytes[3] = 8'h00;
      for (int i = 0; i < 3; i++) load_byte(bytes[i], 1'b0);
      n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL load4_hold_before got %b want 1", cpu_hold); end
      n_checks++; if (load_count !== 9'd3) begin n_fail++; $display("FAIL load4_count3 got %0d want 3", load_count); end
      load_byte(bytes[3], 1'b1);
      n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL load4_hold_after got %b want 0", cpu_hold); end
      n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL load4_ready_after got %b want 0", load_ready); end
      n_checks++; if (load_count !== 9'd4) begin n_fail++; $display("FAIL load4_count got %0d want 4", load_count); end
      // Loader inputs ignored in RUN.
      load_byte(8'h99, 1'b0);
      n_checks++; if (load_count !== 9'd4) begin n_fail++; $display("FAIL load4_ignored got %0d want 4", load_count); end
   endtask

   task automatic test_read();
      logic [7:0] d;
      logic       r;
      do_read(8'h00, d, r);
      n_checks++; if (d !== 8'h04) begin n_fail++; $display("FAIL read_00 got %h want 04", d); end
      n_checks++; if (r !== 1'b1) begin n_fail++; $display("FAIL read_00_ready got %b want 1", r); end
      do_read(8'h03, d, r);
      n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL read_03 got %h want 00", d); end
      do_read(8'h02, d, r);
      n_checks++; if (d !== 8'h12) begin n_fail++; $display("FAIL read_02 got %h want 12", d); end
      read_en = 1'b0;
      #1;
      n_checks++; if (data_bus !== 8'hFF) begin n_fail++; $display("FAIL read_idle_z got %h want FF(pulled)", data_bus); end
      tick();
   endtask

   task automatic test_write();
      logic [7:0] d;
      logic       r;
      addr_bus  = 8'h10;
      tb_drv    = 8'hA5;
      tb_drv_en = 1'b1;
      write_en  = 1'b1;
      tick();
      write_en  = 1'b0;
      tb_drv_en = 1'b0;
      do_read(8'h10, d, r);
      n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL write_readback got %h want A5", d); end
      n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL write_bus_err got %b want 0", bus_err); end
      read_en = 1'b0;
      tick();
   endtask

   task automatic test_rw_conflict();
      logic [7:0] d;
      logic       r;
      addr_bus = 8'h01;
      write_en = 1'b1;
      do_read(8'h01, d, r);
      n_checks++; if (d !== 8'h74) begin n_fail++; $display("FAIL conflict_read got %h want 74", d); end
      tick();
      n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL conflict_bus_err got %b want 1", bus_err); end
      write_en = 1'b0;
      read_en  = 1'b0;
      tick();
      tick();
      n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL conflict_sticky got %b want 1", bus_err); end
      do_read(8'h01, d, r);
      n_checks++; if (d !== 8'h74) begin n_fail++; $display("FAIL conflict_mem_kept got %h want 74", d); end
      read_en = 1'b0;
      tick();
   endtask

   task automatic test_full_load();
      logic [7:0] d;
      logic       r;
      reset = 1'b0;
      #2;
      reset = 1'b1;
      tick();
      n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL full_err_cleared got %b want 0", bus_err); end
      for (int i = 0; i < 256; i++) begin
         load_byte(8'(i) ^ 8'hC3, 1'b0);
         if (i == 254) begin
            n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL full_hold_254 got %b want 1", cpu_hold); end
            n_checks++; if (load_count !== 9'd255) begin n_fail++; $display("FAIL full_count_255 got %0d want 255", load_count); end
         end
      end
      n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL full_hold_end got %b want 0", cpu_hold); end
      n_checks++; if (load_count !== 9'd256) begin n_fail++; $display("FAIL full_count got %0d want 256", load_count); end
      load_byte(8'h99, 1'b0);
      n_checks++; if (load_count !== 9'd256) begin n_fail++; $display("FAIL full_257th got %0d want 256", load_count); end
      n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", load_ready); end
      do_read(8'h00, d, r);
      n_checks++; if (d !== 8'hC3) begin n_fail++; $display("FAIL full_read_00 got %h want C3", d); end
      do_read(8'h80, d, r);
      n_checks++; if (d !== 8'h43) begin n_fail++; $display("FAIL full_read_80 got %h want 43", d); end
      do_read(8'hFF, d, r);
      n_checks++; if (d !== 8'h3C) begin n_fail++; $display("FAIL full_read_FF got %h want 3C", d); end
      read_en = 1'b0;
      tick();
   endtask

   task automatic test_partial_reset();
      logic [7:0] d;
      logic       r;
      reset = 1'b0;
      #2;
      reset = 1'b1;
      tick();
      load_byte(8'hAA, 1'b0);
      load_byte(8'hBB, 1'b0);
      read_en = 1'b1;
      #1;
      n_checks++; if (data_bus !== 8'hFF) begin n_fail++; $display("FAIL load_read_z got %h want FF(pulled)", data_bus); end
      tick();
      read_en = 1'b0;
      n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL load_read_err got %b want 1", bus_err); end
      n_checks++; if (load_count !== 9'd2) begin n_fail++; $display("FAIL partial_count2 got %0d want 2", load_count); end
      reset = 1'b0;
      #1;
      n_checks++; if (load_count !== 9'd0) begin n_fail++; $display("FAIL partial_reset_count got %0d want 0", load_count); end
      n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL partial_reset_hold got %b want 1", cpu_hold); end
      n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL partial_reset_err got %b want 0", bus_err); end
      tick();
      reset = 1'b1;
      tick();
      load_byte(8'h55, 1'b1);
      n_checks++; if (load_count !== 9'd1) begin n_fail++; $display("FAIL one_byte_count got %0d want 1", load_count); end
      n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL one_byte_hold got %b want 0", cpu_hold); end
      do_read(8'h00, d, r);
      n_checks++; if (d !== 8'h55) begin n_fail++; $display("FAIL one_byte_read_00 got %h want 55", d); end
      do_read(8'h01, d, r);
      n_checks++; if (d !== 8'hBB) begin n_fail++; $display("FAIL retained_read_01 got %h want BB", d); end
      do_read(8'h02, d, r);
      n_checks++; if (d !== 8'hC1) begin n_fail++; $display("FAIL retained_read_02 got %h want C1", d); end
      read_en = 1'b0;
      tick();
   endtask

   initial begin
      reset      = 1'b0;
      addr_bus   = 8'h00;
      read_en    = 1'b0;
      write_en   = 1'b0;
      load_valid = 1'b0;
      load_data  = 8'h00;
      load_last  = 1'b0;
      tb_drv     = 8'h00;
      tb_drv_en  = 1'b0;
      #1;
      test_reset();
      test_load4();
      test_read();
      test_write();
      test_rw_conflict();
      test_full_load();
      test_partial_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
